fir_mac_sequencer: RTL and testbench

Sequencer for the FIR filter datapath. It accepts one input sample per handshake and stores it in an internal circular delay line. It then walks the coefficient RAM address from 0 to LENGTH-1, one tap per cycle, forming the signed dot product y[n] = sum c[k]·x[n-k]. The result is presented on a valid/ready output port. It drives the coefficient RAM's combinational read port directly and is the only master of that RAM's address.

---
 rtl/fir_mac_sequencer.sv | 136 +++++++++++++
 tb/tb_fir_mac_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_sequencer.sv
// Sequencer for a single-MAC FIR datapath: buffers one sample in a circular delay
// line, walks the coefficient RAM one tap per cycle, then presents y[n] on valid/ready.
module fir_mac_sequencer #(
  parameter int LENGTH = 64,
  parameter int WIDTH  = 16,
  parameter int ADDR_W = $clog2(LENGTH),
  parameter int ACC_W  = 2*WIDTH+ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_sample,
  input  logic              clear,
  output logic [ADDR_W-1:0] coeff_addr,
  input  logic [WIDTH-1:0]  coeff_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              busy
);

  localparam int IDX_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(LENGTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [WIDTH-1:0]         dly_q [LENGTH];
  logic [WIDTH-1:0]         dly_d [LENGTH];
  logic [ADDR_W-1:0]        wp_q, wp_d;
  logic [ADDR_W-1:0]        k_q, k_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  out_q, out_d;

  logic [IDX_W-1:0]         rd_sum;
  logic [ADDR_W-1:0]        rd_idx;
  logic signed [WIDTH-1:0]  coeff_s;
  logic signed [WIDTH-1:0]  samp_s;
  logic signed [ACC_W-1:0]  prod;

  // (wp - k) mod LENGTH without relying on power-of-two wrap of the pointer width
  always_comb begin
    if (wp_q >= k_q) begin
      rd_sum = {1'b0, wp_q} - {1'b0, k_q};
    end else begin
      rd_sum = {1'b0, wp_q} + IDX_W'(LENGTH) - {1'b0, k_q};
    end
    rd_idx = rd_sum[ADDR_W-1:0];
  end

  assign coeff_s = coeff_data;
  assign samp_s  = dly_q[rd_idx];
  assign prod    = ACC_W'(coeff_s) * ACC_W'(samp_s);

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    wp_d    = wp_q;
    k_d     = k_q;
    acc_d   = acc_q;
    out_d   = out_q;
    case (state_q)
      S_IDLE: begin
        if (clear) begin
          for (int i = 0; i < LENGTH; i++) begin
            dly_d[i] = '0;
          end
          wp_d = '0;
        end else if (in_valid) begin
          dly_d[wp_q] = in_sample;
          acc_d       = '0;
          k_d         = '0;
          state_d     = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_q + prod;
        if (k_q == LAST_TAP) begin
          wp_d    = (wp_q == LAST_TAP) ? '0 : wp_q + ADDR_W'(1);
          k_d     = '0;
          out_d   = acc_q + prod;
          state_d = S_DONE;
        end else begin
          k_d = k_q + ADDR_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wp_q    <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
    end
  end

  // Delay line stays in flops so reset and clear can zero every entry at once
  for (genvar gi = 0; gi < LENGTH; gi++) begin : g_dly
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dly_q[gi] <= '0;
      end else begin
        dly_q[gi] <= dly_d[gi];
      end
    end
  end

  assign in_ready   = (state_q == S_IDLE) && !clear;
  assign coeff_addr = (state_q == S_MAC) ? k_q : '0;
  assign out_valid  = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign out_data   = out_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer (LENGTH=4): dot-product model over an accepted-sample
// history, cycle-by-cycle compare against the timing rules, plus directed literals.
module tb_fir_mac_sequencer;
  localparam int LEN  = 4;
  localparam int W    = 16;
  localparam int AW   = 2;
  localparam int ACCW = 2*W + AW;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [W-1:0]    in_sample = '0;
  logic            clear = 1'b0;
  logic [AW-1:0]   coeff_addr;
  logic [W-1:0]    coeff_data;
  logic            out_valid;
  logic            out_ready;
  logic [ACCW-1:0] out_data;
  logic            busy;

  logic            rand_mode = 1'b0;
  logic            ready_force = 1'b1;
  logic            rnd_ready;
  logic signed [W-1:0] coef [LEN];

  int checks = 0;
  int failures = 0;

  longint hist [LEN];
  longint expq [$];
  longint got [$];
  longint want [$];
  int     stim [$];
  int     phase = -1;
  longint last_out = 0;
  int     lat = 0;
  int     lat_last = 0;
  bit     lat_run = 0;

  fir_mac_sequencer #(.LENGTH(LEN), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sample(in_sample), .clear(clear), .coeff_addr(coeff_addr),
    .coeff_data(coeff_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  assign coeff_data = coef[coeff_addr];
  assign out_ready  = rand_mode ? rnd_ready : ready_force;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sdata();
    return longint'($signed(out_data));
  endfunction

  // Expectations follow the timing rules: handshake edge T, MAC T+1..T+LEN, DONE from T+LEN+1.
  task automatic monitor_loop();
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < LEN; i++) hist[i] = 0;
        expq.delete();
        phase = -1;
        last_out = 0;
        lat_run = 0;
      end else begin
        bit in_hs;
        bit out_hs;
        longint y;
        in_hs  = in_valid && in_ready;
        out_hs = out_valid && out_ready;
        if (phase == -1) begin
          chk("idle_out_valid", out_valid, 0);
          chk("idle_busy", busy, 0);
          chk("idle_coeff_addr", coeff_addr, 0);
          chk("idle_in_ready", in_ready, !clear);
          chk("idle_out_data_hold", sdata(), last_out);
        end else if (phase <= LEN) begin
          chk("mac_coeff_addr", coeff_addr, phase - 1);
          chk("mac_out_valid", out_valid, 0);
          chk("mac_busy", busy, 1);
          chk("mac_in_ready", in_ready, 0);
        end else begin
          chk("done_out_valid", out_valid, 1);
          chk("done_busy", busy, 1);
          chk("done_in_ready", in_ready, 0);
          chk("done_coeff_addr", coeff_addr, 0);
          chk("done_out_data", sdata(), expq[0]);
        end
        if (lat_run) begin
          lat++;
          if (out_valid) begin
            lat_last = lat;
            lat_run = 0;
          end else if (lat > 50) begin
            lat_run = 0;
          end
        end
        if (phase == -1) begin
          if (clear) begin
            for (int i = 0; i < LEN; i++) hist[i] = 0;
          end else if (in_hs) begin
            for (int i = LEN - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = longint'($signed(in_sample));
            y = 0;
            for (int i = 0; i < LEN; i++) y += longint'(coef[i]) * hist[i];
            expq.push_back(y);
            phase = 1;
            lat = 0;
            lat_run = 1;
          end
        end else if (phase <= LEN) begin
          phase++;
        end else if (out_hs) begin
          got.push_back(sdata());
          last_out = expq.pop_front();
          phase = -1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_coef(input int a, input int b, input int c, input int d);
    coef[0] = W'(a);
    coef[1] = W'(b);
    coef[2] = W'(c);
    coef[3] = W'(d);
  endtask

  task automatic send(input int x);
    bit hs;
    int n;
    in_sample = W'(x);
    in_valid  = 1'b1;
    hs = 0;
    n = 0;
    while (!hs && n < 300) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    chk("send_handshake", hs, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    int n;
    ok = 0;
    n = 0;
    while (!ok && n < 300) begin
      @(negedge clk);
      ok = !busy && (phase == -1) && (expq.size() == 0);
      n++;
    end
    chk("wait_idle", ok, 1);
    tick();
  endtask

  task automatic clear_line();
    wait_idle();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic run_and_check(input string name);
    got.delete();
    foreach (stim[i]) send(stim[i]);
    wait_idle();
    chk({name, "_count"}, got.size(), want.size());
    foreach (want[i]) begin
      if (i < got.size()) chk(name, got[i], want[i]);
    end
  endtask

  initial begin
    set_coef(1, 2, 3, 4);
    fork
      monitor_loop();
    join_none
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_coeff_addr", coeff_addr, 0);
    chk("rst_out_data", sdata(), 0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    tick();

    // Impulse
    stim = '{1, 0, 0, 0, 0};
    want = '{1, 2, 3, 4, 0};
    run_and_check("impulse");
    chk("impulse_latency", lat_last, 5);

    // Step through two pointer wraps
    clear_line();
    stim = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    want = '{1, 3, 6, 10, 10, 10, 10, 10, 10};
    run_and_check("step");

    // Signed extremes
    clear_line();
    set_coef(-32768, -32768, -32768, -32768);
    stim = '{-32768, -32768, -32768, -32768};
    want = '{64'sd1073741824, 64'sd2147483648, 64'sd3221225472, 64'sd4294967296};
    run_and_check("neg_extreme");
    clear_line();
    set_coef(32767, -32768, 32767, -32768);
    stim = '{1, 1, 1, 1};
    want = '{32767, -1, 32766, -2};
    run_and_check("alt_extreme");

    // Back-pressure for 10 cycles in DONE
    clear_line();
    set_coef(1, 2, 3, 4);
    got.delete();
    ready_force = 1'b0;
    send(3);
    begin
      bit seen;
      int n;
      seen = 0;
      n = 0;
      while (!seen && n < 50) begin
        @(negedge clk);
        seen = out_valid;
        n++;
      end
      chk("bp_out_valid_rise", seen, 1);
    end
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_data", sdata(), 3);
      chk("bp_hold_in_ready", in_ready, 0);
      chk("bp_hold_busy", busy, 1);
    end
    tick();
    ready_force = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_out_valid", out_valid, 0);
    chk("bp_result_count", got.size(), 1);
    if (got.size() > 0) chk("bp_result", got[0], 3);
    tick();

    // Clear ignores a simultaneous sample and flushes history
    clear_line();
    stim = '{5, 7};
    want = '{5, 17};
    run_and_check("pre_clear");
    clear = 1'b1;
    in_valid = 1'b1;
    in_sample = W'(9);
    @(negedge clk);
    chk("clear_blocks_in_ready", in_ready, 0);
    tick();
    clear = 1'b0;
    in_valid = 1'b0;
    stim = '{1};
    want = '{1};
    run_and_check("post_clear");

    // Asynchronous reset while k=2
    clear_line();
    got.delete();
    send(1);
    tick();
    tick();
    chk("pre_rst_coeff_addr", coeff_addr, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_coeff_addr", coeff_addr, 0);
    chk("rst_mid_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_mid_in_ready", in_ready, 1);
    chk("rst_mid_no_output", got.size(), 0);
    tick();
    stim = '{1, 0, 0, 0};
    want = '{1, 2, 3, 4};
    run_and_check("post_rst_impulse");

    // Randomized traffic with random back-pressure, coefficient changes and clears
    rand_mode = 1'b1;
    for (int it = 0; it < 60; it++) begin
      int r;
      int x;
      r = $urandom_range(0, 5);
      if (r == 0) begin
        wait_idle();
        for (int i = 0; i < LEN; i++) begin
          coef[i] = ($urandom_range(0, 4) == 0) ? W'(16'h8000) : W'($urandom);
        end
      end else if (r == 1) begin
        clear_line();
      end
      repeat ($urandom_range(0, 3)) tick();
      x = ($urandom_range(0, 4) == 0) ? -32768 : int'($signed(W'($urandom)));
      send(x);
    end
    wait_idle();
    rand_mode = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
